tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_sequencer_if.sv | 29 ++
 rtl/tone_sequencer.sv | 165 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// Control and status bundle of the tone sequencer. The master drives note-table
// writes and play/stop requests; the slave (the sequencer) drives the buzzer and status.
interface tone_sequencer_if #(
    parameter int IDX_W = 5,
    parameter int HP_W  = 24
);
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [HP_W-1:0]  wr_hp;
    logic [1:0]       wr_dur;
    logic [IDX_W-1:0] last_idx;
    logic             loop;
    logic             start;
    logic             stop;
    logic             buzz;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] cur_idx;

    modport master (
        output wr_en, wr_addr, wr_hp, wr_dur, last_idx, loop, start, stop,
        input  buzz, busy, done, cur_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_hp, wr_dur, last_idx, loop, start, stop,
        output buzz, busy, done, cur_idx
    );
endinterface

// File: rtl/tone_sequencer.sv
// Note-table driven square-wave buzzer sequencer: each note is a one-cycle LOAD,
// a TONE of WHOLE_CYC>>code cycles and a silent GAP of GAP_CYC cycles.
module tone_sequencer #(
    parameter int DEPTH     = 32,
    parameter int HP_W      = 24,
    parameter int WHOLE_CYC = 100_000_000,
    parameter int GAP_CYC   = 1_000_000
) (
    input logic            clk,
    input logic            rst_n,
    tone_sequencer_if.slave ts
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_MAX = (WHOLE_CYC > GAP_CYC) ? WHOLE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WHOLE_L = CNT_W'(WHOLE_CYC);
    localparam logic [CNT_W-1:0] GAP_L   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [HP_W-1:0]  HP_ONE  = HP_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] curIdx_q, curIdx_d;
    logic [IDX_W-1:0] lastIdx_q, lastIdx_d;
    logic             loop_q, loop_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [HP_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             buzz_q, buzz_d;
    logic             donePulse;
    logic             noteEnd;

    // Table is deliberately unreset so a song survives rst_n.
    logic [HP_W+1:0]  noteMem [DEPTH];
    logic [HP_W+1:0]  entry;
    logic [HP_W-1:0]  entryHp;
    logic [1:0]       entryDur;

    always_ff @(posedge clk) begin
        if (ts.wr_en && ({1'b0, ts.wr_addr} < DEPTH_L)) begin
            noteMem[ts.wr_addr] <= {ts.wr_hp, ts.wr_dur};
        end
    end

    assign entry    = noteMem[curIdx_q];
    assign entryHp  = entry[HP_W+1:2];
    assign entryDur = entry[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            curIdx_q  <= '0;
            lastIdx_q <= '0;
            loop_q    <= 1'b0;
            hp_q      <= '0;
            div_q     <= '0;
            tmr_q     <= '0;
            buzz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            curIdx_q  <= curIdx_d;
            lastIdx_q <= lastIdx_d;
            loop_q    <= loop_d;
            hp_q      <= hp_d;
            div_q     <= div_d;
            tmr_q     <= tmr_d;
            buzz_q    <= buzz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        curIdx_d  = curIdx_q;
        lastIdx_d = lastIdx_q;
        loop_d    = loop_q;
        hp_d      = hp_q;
        div_d     = div_q;
        tmr_d     = tmr_q;
        buzz_d    = buzz_q;
        donePulse = 1'b0;
        noteEnd   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ts.start && !ts.stop) begin
                    lastIdx_d = (ts.last_idx > IDX_MAX) ? IDX_MAX : ts.last_idx;
                    loop_d    = ts.loop;
                    curIdx_d  = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                hp_d    = entryHp;
                tmr_d   = WHOLE_L >> entryDur;
                div_d   = '0;
                buzz_d  = 1'b0;
                state_d = TONE;
            end
            TONE: begin
                if (tmr_q <= CNT_ONE) begin
                    buzz_d = 1'b0;
                    div_d  = '0;
                    if (GAP_CYC == 0) begin
                        noteEnd = 1'b1;
                    end else begin
                        tmr_d   = GAP_L;
                        state_d = GAP;
                    end
                end else begin
                    tmr_d = tmr_q - CNT_ONE;
                    // A rest holds the divider so it can never run into wrap.
                    if (hp_q != '0) begin
                        if (div_q == hp_q - HP_ONE) begin
                            buzz_d = ~buzz_q;
                            div_d  = '0;
                        end else begin
                            div_d = div_q + HP_ONE;
                        end
                    end
                end
            end
            GAP: begin
                if (tmr_q <= CNT_ONE) begin
                    noteEnd = 1'b1;
                end else begin
                    tmr_d = tmr_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (noteEnd) begin
            if (curIdx_q < lastIdx_q) begin
                curIdx_d = curIdx_q + IDX_ONE;
                state_d  = LOAD;
            end else if (loop_q) begin
                curIdx_d = '0;
                state_d  = LOAD;
            end else begin
                donePulse = 1'b1;
                state_d   = IDLE;
            end
        end

        // Stop overrides everything, including a done that would fire this cycle.
        if (ts.stop && state_q != IDLE) begin
            state_d   = IDLE;
            curIdx_d  = curIdx_q;
            buzz_d    = 1'b0;
            div_d     = '0;
            tmr_d     = '0;
            donePulse = 1'b0;
        end
    end

    assign ts.buzz    = buzz_q;
    assign ts.busy    = (state_q != IDLE);
    assign ts.done    = donePulse;
    assign ts.cur_idx = curIdx_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: each song start pushes the expected per-cycle
// busy/done/buzz/cur_idx trace, which is popped and compared as the DUT plays.
module tb_tone_sequencer;
    localparam int DEPTH     = 4;
    localparam int HP_W      = 8;
    localparam int WHOLE_CYC = 64;
    localparam int GAP_CYC   = 2;
    localparam int IDX_W     = $clog2(DEPTH);

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             buzz;
        logic [IDX_W-1:0] idx;
    } obs_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    obs_t expQ[$];

    tone_sequencer_if #(.IDX_W(IDX_W), .HP_W(HP_W)) tsIf ();

    tone_sequencer #(
        .DEPTH(DEPTH), .HP_W(HP_W), .WHOLE_CYC(WHOLE_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ts   (tsIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t mk(input logic b, input logic d, input logic z, input int idx);
        obs_t r;
        r.busy = b;
        r.done = d;
        r.buzz = z;
        r.idx  = IDX_W'(idx);
        return r;
    endfunction

    // Expected trace of one note: LOAD, TONE (square wave of period 2*hp), GAP.
    task automatic push_note(input int hp, input int code, input int idx, input bit fin);
        int dur = WHOLE_CYC >> code;
        expQ.push_back(mk(1'b1, 1'b0, 1'b0, idx));
        for (int t = 1; t <= dur; t++) begin
            expQ.push_back(mk(1'b1, 1'b0, (hp == 0) ? 1'b0 : 1'(((t - 1) / hp) % 2), idx));
        end
        for (int g = 1; g <= GAP_CYC; g++) begin
            expQ.push_back(mk(1'b1, fin && (g == GAP_CYC), 1'b0, idx));
        end
    endtask

    // Advance one clock, drop the single-cycle strobes and capture the outputs.
    task automatic sample(output obs_t o);
        @(posedge clk);
        #1;
        tsIf.start = 1'b0;
        tsIf.stop  = 1'b0;
        tsIf.wr_en = 1'b0;
        o = {tsIf.busy, tsIf.done, tsIf.buzz, tsIf.cur_idx};
    endtask

    task automatic write_entry(input int a, input int hp, input int code);
        obs_t o;
        tsIf.wr_en   = 1'b1;
        tsIf.wr_addr = IDX_W'(a);
        tsIf.wr_hp   = HP_W'(hp);
        tsIf.wr_dur  = 2'(code);
        sample(o);
    endtask

    task automatic start_song(input int last, input bit lp);
        tsIf.last_idx = IDX_W'(last);
        tsIf.loop     = lp;
        tsIf.start    = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        tsIf.wr_en = 1'b0; tsIf.wr_addr = '0; tsIf.wr_hp = '0; tsIf.wr_dur = '0;
        tsIf.last_idx = '0; tsIf.loop = 1'b0; tsIf.start = 1'b0; tsIf.stop = 1'b0;
        #12;
        o = {tsIf.busy, tsIf.done, tsIf.buzz, tsIf.cur_idx};
        total++;
        if (o !== mk(1'b0, 1'b0, 1'b0, 0)) begin
            bad++;
            $display("[TB] FAIL reset_state got=%b want=%b", o, mk(1'b0, 1'b0, 1'b0, 0));
        end
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sample(o);
        total++;
        if (o !== mk(1'b0, 1'b0, 1'b0, 0)) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%b want=%b", o, mk(1'b0, 1'b0, 1'b0, 0));
        end
    endtask

    task automatic test_single_note();
        obs_t o, e;
        int   cyc = 1;
        write_entry(0, 4, 2);
        start_song(0, 1'b0);
        push_note(4, 2, 0, 1'b1);
        repeat (2) expQ.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        while (expQ.size() > 0) begin
            sample(o);
            e = expQ.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL single_note cyc=%0d got b/d/z/i=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, o.busy, o.done, o.buzz, o.idx, e.busy, e.done, e.buzz, e.idx);
            end
            cyc++;
        end
    endtask

    task automatic test_rest_sequence();
        obs_t o, e;
        int   cyc = 1;
        write_entry(0, 0, 3);
        write_entry(1, 2, 3);
        start_song(1, 1'b0);
        push_note(0, 3, 0, 1'b0);
        push_note(2, 3, 1, 1'b1);
        expQ.push_back(mk(1'b0, 1'b0, 1'b0, 1));
        while (expQ.size() > 0) begin
            sample(o);
            e = expQ.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL rest_sequence cyc=%0d got b/d/z/i=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, o.busy, o.done, o.buzz, o.idx, e.busy, e.done, e.buzz, e.idx);
            end
            cyc++;
        end
    endtask

    task automatic test_loop_stop();
        obs_t o, e;
        int   cyc = 1;
        start_song(1, 1'b1);
        push_note(0, 3, 0, 1'b0);
        push_note(2, 3, 1, 1'b0);
        push_note(0, 3, 0, 1'b0);
        push_note(2, 3, 1, 1'b0);
        // Play until the third TONE cycle of the second pass of entry1, where buzz is high.
        while (expQ.size() > 7) begin
            sample(o);
            e = expQ.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL loop_wrap cyc=%0d got b/d/z/i=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, o.busy, o.done, o.buzz, o.idx, e.busy, e.done, e.buzz, e.idx);
            end
            cyc++;
        end
        expQ.delete();
        tsIf.stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample(o);
            total++;
            if ({o.busy, o.done, o.buzz} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL stop_idle k=%0d got b/d/z=%b/%b/%b want 0/0/0",
                         k, o.busy, o.done, o.buzz);
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t o, e;
        int   cyc = 1;
        start_song(1, 1'b0);
        tsIf.stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample(o);
            total++;
            if ({o.busy, o.done, o.buzz} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL start_stop_same k=%0d got b/d/z=%b/%b/%b want 0/0/0",
                         k, o.busy, o.done, o.buzz);
            end
        end
        start_song(1, 1'b0);
        push_note(0, 3, 0, 1'b0);
        push_note(2, 3, 1, 1'b1);
        expQ.push_back(mk(1'b0, 1'b0, 1'b0, 1));
        while (expQ.size() > 0) begin
            sample(o);
            e = expQ.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL start_while_busy cyc=%0d got b/d/z/i=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, o.busy, o.done, o.buzz, o.idx, e.busy, e.done, e.buzz, e.idx);
            end
            if (cyc == 14) start_song(0, 1'b1);
            cyc++;
        end
    endtask

    task automatic test_reset_mid_note();
        obs_t o, e;
        int   cyc = 1;
        write_entry(0, 4, 2);
        write_entry(1, 3, 2);
        start_song(1, 1'b0);
        push_note(4, 2, 0, 1'b0);
        push_note(3, 2, 1, 1'b1);
        while (cyc <= 24) begin
            sample(o);
            e = expQ.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL pre_reset cyc=%0d got b/d/z/i=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, o.busy, o.done, o.buzz, o.idx, e.busy, e.done, e.buzz, e.idx);
            end
            cyc++;
        end
        expQ.delete();
        rst_n = 1'b0;
        #1;
        o = {tsIf.busy, tsIf.done, tsIf.buzz, tsIf.cur_idx};
        total++;
        if (o !== mk(1'b0, 1'b0, 1'b0, 0)) begin
            bad++;
            $display("[TB] FAIL async_reset got=%b want=%b", o, mk(1'b0, 1'b0, 1'b0, 0));
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        start_song(1, 1'b0);
        push_note(4, 2, 0, 1'b0);
        push_note(3, 2, 1, 1'b1);
        expQ.push_back(mk(1'b0, 1'b0, 1'b0, 1));
        while (expQ.size() > 0) begin
            sample(o);
            e = expQ.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL replay_after_reset cyc=%0d got b/d/z/i=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, o.busy, o.done, o.buzz, o.idx, e.busy, e.done, e.buzz, e.idx);
            end
            cyc++;
        end
    endtask

    task automatic test_live_write_clamp();
        obs_t o, e;
        int   cyc = 1;
        write_entry(0, 0, 3);
        write_entry(1, 2, 3);
        write_entry(2, 3, 3);
        write_entry(3, 2, 3);
        // All-ones is the largest index the port can carry; the song must end after entry3.
        tsIf.last_idx = '1;
        tsIf.loop     = 1'b0;
        tsIf.start    = 1'b1;
        push_note(0, 3, 0, 1'b0);
        push_note(1, 3, 1, 1'b0);
        push_note(3, 3, 2, 1'b0);
        push_note(2, 3, 3, 1'b1);
        repeat (2) expQ.push_back(mk(1'b0, 1'b0, 1'b0, 3));
        while (expQ.size() > 0) begin
            sample(o);
            e = expQ.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL live_write_clamp cyc=%0d got b/d/z/i=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, o.busy, o.done, o.buzz, o.idx, e.busy, e.done, e.buzz, e.idx);
            end
            if (cyc == 3) begin
                tsIf.wr_en   = 1'b1;
                tsIf.wr_addr = IDX_W'(1);
                tsIf.wr_hp   = HP_W'(1);
                tsIf.wr_dur  = 2'(3);
            end
            cyc++;
        end
    endtask

    initial begin
        $display("[TB] tone_sequencer bench starting");
        test_reset();
        test_single_note();
        test_rest_sequence();
        test_loop_stop();
        test_simultaneous();
        test_reset_mid_note();
        test_live_write_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
